// File: rtl/loc_buf_ctrl.sv
// loc_buf_ctrl: port controller for the 16-row local-buffer SRAM. Coalesces element writes into one masked row write and returns full rows with hazard protection.
// Latency: a write is pending until committed (row switch, flush, read hazard or full row); a read returns rd_data_valid in the cycle after the third edge from accept.
// Backpressure: wr_ready drops on commit cycles for flush, hazard and full row (and in R_ISSUE when LOC_RD_CLEAR_EN is defined); rd_ready drops on hazard and while a read is in flight.
//
// Optional feature macro: LOC_RD_CLEAR_EN (destructive read, the row is zeroed in R_ISSUE).
// Ports: clk, rst_n; write request wr_valid/wr_ready/wr_row/wr_lane/wr_data; flush;
//        read request rd_valid/rd_ready/rd_row and response rd_data_valid/rd_data; pend;
//        SRAM side sram_wsb/sram_bytemask/sram_wdata/sram_waddr/sram_raddr/sram_rdata.
// Lane mapping: vid v lives at mask bit D-1-v and data bits [(D-1-v)*BW +: BW].
module loc_buf_ctrl #(
  parameter int ADDR_SPACE = 8,
  parameter int BW         = 5,
  parameter int D          = 256,
  parameter int LANE_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_SPACE-1:0] wr_row,
  input  logic [LANE_W-1:0]     wr_lane,
  input  logic [BW-1:0]         wr_data,
  input  logic                  flush,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_SPACE-1:0] rd_row,
  output logic                  rd_data_valid,
  output logic [D*BW-1:0]       rd_data,
  output logic                  pend,
  output logic                  sram_wsb,
  output logic [D-1:0]          sram_bytemask,
  output logic [D*BW-1:0]       sram_wdata,
  output logic [ADDR_SPACE-1:0] sram_waddr,
  output logic [ADDR_SPACE-1:0] sram_raddr,
  input  logic [D*BW-1:0]       sram_rdata
);

  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_CAP} rstate_t;

  rstate_t               rstate_q;
  logic                  pend_q, pend_d;
  logic [ADDR_SPACE-1:0] pend_row_q, pend_row_d;
  // Mask and data are stored already in SRAM lane order.
  logic [D-1:0]          pend_mask_q, pend_mask_d;
  logic [D*BW-1:0]       pend_data_q, pend_data_d;
  logic                  flush_q, flush_d;

  logic [LANE_W-1:0]     map_idx;
  logic [31:0]           lane_base;
  logic                  hazard, full, clr_cyc, int_trig;
  logic                  wr_acc, rd_acc, commit_row, commit;

  assign map_idx   = LANE_W'(D - 1) - wr_lane;
  assign lane_base = 32'(map_idx) * 32'(BW);

  assign hazard = pend_q && (rstate_q == R_IDLE) && rd_valid && (rd_row == pend_row_q);
  assign full   = &pend_mask_q;

`ifdef LOC_RD_CLEAR_EN
  // The clearing write owns the SRAM port in R_ISSUE, so commits wait a cycle.
  assign clr_cyc = (rstate_q == R_ISSUE);
`else
  assign clr_cyc = 1'b0;
`endif

  // Flush, hazard and full-row commits stall the write port for their cycle.
  assign int_trig   = pend_q && (flush_q || hazard || full);
  assign wr_ready   = !clr_cyc && !int_trig;
  assign wr_acc     = wr_valid && wr_ready;
  assign commit_row = wr_acc && pend_q && (wr_row != pend_row_q);
  assign commit     = (int_trig && !clr_cyc) || commit_row;

  assign rd_ready = (rstate_q == R_IDLE) && !hazard;
  assign rd_acc   = rd_valid && rd_ready;
  assign pend     = pend_q;

  // SRAM write port is purely combinational from the pending state.
  always_comb begin
    sram_wsb      = 1'b1;
    sram_bytemask = '1;
    sram_wdata    = '0;
    sram_waddr    = '0;
    if (clr_cyc) begin
      sram_wsb      = 1'b0;
      sram_waddr    = sram_raddr;
      sram_bytemask = '0;
    end else if (commit) begin
      sram_wsb      = 1'b0;
      sram_waddr    = pend_row_q;
      sram_bytemask = ~pend_mask_q;
      sram_wdata    = pend_data_q;
    end
  end

  // Coalescing buffer next state. A row-switch commit and the new load share one edge.
  always_comb begin
    pend_d      = pend_q;
    pend_row_d  = pend_row_q;
    pend_mask_d = pend_mask_q;
    pend_data_d = pend_data_q;
    if (commit) begin
      pend_d      = 1'b0;
      pend_mask_d = '0;
      pend_data_d = '0;
    end
    if (wr_acc) begin
      if (!pend_q || commit_row) begin
        pend_row_d  = wr_row;
        pend_mask_d = '0;
        pend_data_d = '0;
      end
      pend_d                         = 1'b1;
      pend_mask_d[map_idx]           = 1'b1;
      pend_data_d[lane_base +: BW]   = wr_data;
    end
  end

  // flush_q is held until a commit services it, or dropped if nothing is pending.
  always_comb begin
    flush_d = flush_q;
    if (flush_q && (!pend_q || commit)) flush_d = 1'b0;
    if (flush) flush_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= 1'b0;
      pend_row_q  <= '0;
      pend_mask_q <= '0;
      pend_data_q <= '0;
      flush_q     <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      pend_row_q  <= pend_row_d;
      pend_mask_q <= pend_mask_d;
      pend_data_q <= pend_data_d;
      flush_q     <= flush_d;
    end
  end

  // Read FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate_q      <= R_IDLE;
      sram_raddr    <= '0;
      rd_data       <= '0;
      rd_data_valid <= 1'b0;
    end else begin
      rd_data_valid <= 1'b0;
      case (rstate_q)
        R_IDLE: begin
          if (rd_acc) begin
            sram_raddr <= rd_row;
            rstate_q   <= R_ISSUE;
          end
        end
        R_ISSUE: rstate_q <= R_CAP;
        R_CAP: begin
          rd_data       <= sram_rdata;
          rd_data_valid <= 1'b1;
          rstate_q      <= R_IDLE;
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_loc_buf_ctrl.sv
module tb_loc_buf_ctrl;
  localparam int D  = 256;
  localparam int BW = 5;
  localparam int W  = D * BW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_valid, wr_ready, flush, rd_valid, rd_ready, rd_data_valid, pend;
  logic [7:0]    wr_row, wr_lane, rd_row, sram_waddr, sram_raddr;
  logic [4:0]    wr_data;
  logic [W-1:0]  rd_data, sram_wdata, sram_rdata;
  logic          sram_wsb;
  logic [D-1:0]  sram_bytemask;

  loc_buf_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_row(wr_row), .wr_lane(wr_lane), .wr_data(wr_data),
    .flush(flush),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_row(rd_row),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data), .pend(pend),
    .sram_wsb(sram_wsb), .sram_bytemask(sram_bytemask), .sram_wdata(sram_wdata),
    .sram_waddr(sram_waddr), .sram_raddr(sram_raddr), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int stalls = 0;
  int last_n = 0;

  // SRAM model: read-before-write, registered read data, per-lane write mask.
  logic [W-1:0] mem [0:255];
  always @(posedge clk) begin
    sram_rdata <= mem[sram_raddr];
    if (!sram_wsb)
      for (int l = 0; l < D; l++)
        if (!sram_bytemask[l]) mem[sram_waddr][l*BW +: BW] = sram_wdata[l*BW +: BW];
  end

  typedef struct {
    logic [7:0]   addr;
    logic [D-1:0] mask;
    logic [W-1:0] data;
  } cexp_t;

  cexp_t        cq[$];
  logic [W-1:0] rq[$];

  function automatic logic [W-1:0] lane_v(input int vid, input logic [4:0] val);
    logic [W-1:0] r;
    r = '0;
    r[(D-1-vid)*BW +: BW] = val;
    return r;
  endfunction

  function automatic logic [D-1:0] mask_v(input int vid);
    logic [D-1:0] r;
    r = '1;
    r[D-1-vid] = 1'b0;
    return r;
  endfunction

  function automatic int diff_lane(input logic [W-1:0] a, input logic [W-1:0] b);
    for (int i = 0; i < D; i++)
      if (a[(D-1-i)*BW +: BW] !== b[(D-1-i)*BW +: BW]) return i;
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  task automatic push_c(input int row, input logic [D-1:0] m, input logic [W-1:0] d);
    cexp_t e;
    e.addr = 8'(row);
    e.mask = m;
    e.data = d;
    cq.push_back(e);
  endtask

  // Write-port monitor.
  cexp_t ce;
  always @(negedge clk) begin
    if (rst_n && !sram_wsb) begin
      checks++;
      if (cq.size() == 0) begin
        errors++;
        $display("FAIL commit_unexpected waddr got %0d exp no write", sram_waddr);
      end else begin
        ce = cq.pop_front();
        if (sram_waddr !== ce.addr || sram_bytemask !== ce.mask || sram_wdata !== ce.data) begin
          errors++;
          $display("FAIL commit row got %0d exp %0d mask got %h exp %h first bad data lane %0d",
                   sram_waddr, ce.addr, sram_bytemask, ce.mask, diff_lane(sram_wdata, ce.data));
        end
      end
    end
  end

  // Read-response monitor.
  logic [W-1:0] re;
  int           bl;
  always @(negedge clk) begin
    if (rst_n && rd_data_valid) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected got rd_data_valid exp none");
      end else begin
        re = rq.pop_front();
        if (rd_data !== re) begin
          errors++;
          bl = diff_lane(rd_data, re);
          $display("FAIL rd_data lane %0d got %0h exp %0h", bl,
                   rd_data[(D-1-bl)*BW +: BW], re[(D-1-bl)*BW +: BW]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int row, input int lane, input logic [4:0] val);
    int   n;
    logic ok;
    wr_valid = 1'b1; wr_row = 8'(row); wr_lane = 8'(lane); wr_data = val;
    n = 0;
    do begin
      @(negedge clk); ok = wr_ready; n++;
      tick();
    end while (!ok && n < 50);
    wr_valid = 1'b0;
    if (n > 1) stalls += n - 1;
    if (!ok) chk("wr_timeout", 0, 1);
  endtask

  task automatic rd(input int row, input logic [W-1:0] exp, input bit push);
    int   n;
    logic ok;
    rd_valid = 1'b1; rd_row = 8'(row);
    n = 0;
    do begin
      @(negedge clk); ok = rd_ready; n++;
      @(posedge clk);
      if (ok && push) rq.push_back(exp);
      #1;
    end while (!ok && n < 50);
    rd_valid = 1'b0;
    last_n = n;
`ifdef LOC_RD_CLEAR_EN
    if (ok && push) push_c(row, '0, '0);
`endif
    if (!ok) chk("rd_timeout", 0, 1);
  endtask

  task automatic wait_rd();
    int n = 0;
    while (rq.size() != 0 && n < 20) begin @(negedge clk); n++; end
    chk("rd_done", 64'(rq.size()), 0);
    tick();
  endtask

  task automatic wait_c();
    int n = 0;
    while (cq.size() != 0 && n < 20) begin @(negedge clk); n++; end
    chk("commit_done", 64'(cq.size()), 0);
    tick();
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] full_d, exp3, exp2;

  initial begin
    for (int r = 0; r < 256; r++) mem[r] = '0;
    rst_n = 1'b0; wr_valid = 1'b0; flush = 1'b0; rd_valid = 1'b0;
    wr_row = '0; wr_lane = '0; wr_data = '0; rd_row = '0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_rd_ready", rd_ready, 1);
    chk("rst_rd_data_valid", rd_data_valid, 0);
    chk("rst_rd_data_zero", 64'(rd_data != '0), 0);
    chk("rst_pend", pend, 0);
    chk("rst_wsb", sram_wsb, 1);
    chk("rst_mask_ones", 64'(&sram_bytemask), 1);
    chk("rst_wdata_zero", 64'(sram_wdata != '0), 0);
    chk("rst_waddr", sram_waddr, 0);
    chk("rst_raddr", sram_raddr, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Coalesced write with lane overwrite, then flush
    push_c(3, mask_v(0) & mask_v(255), lane_v(0, 5'h1F) | lane_v(255, 5'h0A));
    wr(3, 0, 5'h04);
    wr(3, 0, 5'h1F);
    wr(3, 255, 5'h0A);
    @(negedge clk); chk("coal_pend", pend, 1); chk("coal_no_write", sram_wsb, 1);
    tick();
    pulse_flush();
    wait_c();
    @(negedge clk); chk("coal_pend_clr", pend, 0);
    tick();
    rd(3, lane_v(0, 5'h1F) | lane_v(255, 5'h0A), 1'b1);
    wait_rd();

    // Row switch
    push_c(1, mask_v(4), lane_v(4, 5'h11));
    wr(1, 4, 5'h11);
    wr_valid = 1'b1; wr_row = 8'd2; wr_lane = 8'd6; wr_data = 5'h12;
    @(negedge clk);
    chk("rowsw_wr_ready", wr_ready, 1);
    chk("rowsw_commit", sram_wsb, 0);
    chk("rowsw_waddr", sram_waddr, 1);
    tick();
    wr_valid = 1'b0;
    @(negedge clk); chk("rowsw_pend", pend, 1); chk("rowsw_idle_wsb", sram_wsb, 1);
    tick();
    push_c(2, mask_v(6), lane_v(6, 5'h12));
    pulse_flush();
    wait_c();
    rd(1, lane_v(4, 5'h11), 1'b1);
    wait_rd();
    rd(2, lane_v(6, 5'h12), 1'b1);
    wait_rd();

    // Read hazard
    push_c(5, mask_v(7), lane_v(7, 5'h03));
    wr(5, 7, 5'h03);
    rd_valid = 1'b1; rd_row = 8'd5;
    @(negedge clk);
    chk("haz_rd_ready", rd_ready, 0);
    chk("haz_commit", sram_wsb, 0);
    chk("haz_wr_ready", wr_ready, 0);
    tick();
    rd(5, lane_v(7, 5'h03), 1'b1);
    chk("haz_accept_next", last_n, 1);
    @(negedge clk); chk("rd_busy_issue", rd_ready, 0);
    tick();
    wait_rd();

    // Full row
    full_d = '0;
    for (int v = 0; v < D; v++) full_d[(D-1-v)*BW +: BW] = 5'(v);
    push_c(9, '0, full_d);
    stalls = 0;
    for (int v = 0; v < D; v++) wr(9, v, 5'(v));
    @(negedge clk);
    chk("full_commit_now", sram_wsb, 0);
    chk("full_wr_ready", wr_ready, 0);
    chk("full_no_stalls", stalls, 0);
    tick();
    @(negedge clk); chk("full_pend_clr", pend, 0);
    tick();
    wait_c();
    rd(9, full_d, 1'b1);
    wait_rd();

    // Read twice
    push_c(3, mask_v(10), lane_v(10, 5'h15));
    wr(3, 10, 5'h15);
    pulse_flush();
    wait_c();
`ifdef LOC_RD_CLEAR_EN
    exp3 = lane_v(10, 5'h15);
    rd(3, exp3, 1'b1);
    wait_rd();
    rd(3, '0, 1'b1);
    wait_rd();
    exp2 = '0;
`else
    exp3 = lane_v(0, 5'h1F) | lane_v(255, 5'h0A) | lane_v(10, 5'h15);
    rd(3, exp3, 1'b1);
    wait_rd();
    rd(3, exp3, 1'b1);
    wait_rd();
    exp2 = lane_v(6, 5'h12);
`endif

    // Reset in R_ISSUE with pending data
    wr(2, 0, 5'h07);
    rd(1, '0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_pend", pend, 0);
    chk("mrst_wsb", sram_wsb, 1);
    chk("mrst_rd_data_valid", rd_data_valid, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); chk("mrst_no_rvalid", rd_data_valid, 0);
    end
    tick();
    rd(2, exp2, 1'b1);
    wait_rd();

    chk("end_commit_q", 64'(cq.size()), 0);
    chk("end_rd_q", 64'(rq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/loc_buf_ctrl.md
# loc_buf_ctrl

Port controller for the 16-row x D-lane x BW-bit local-buffer SRAM (`loc_sram_16x1280b`). It sits between the graph engine and the SRAM on both sides of the macro:
- **Write side:** accepts single-element writes (row, vertex lane, value), coalesces same-row writes into one masked SRAM write, and drives `wsb`, `bytemask`, `wdata` and `waddr`.
- **Read side:** returns full rows with hazard protection against uncommitted writes.

## Interface
Parameters:
- ADDR_SPACE, 8, row address width
- BW, 5, bits per lane element
- D, 256, lanes per row
- LANE_W, 8, lane index width, log2(D)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- wr_valid  in  1  element write request
- wr_ready  out  1  write accepted when wr_valid && wr_ready at posedge
- wr_row  in  ADDR_SPACE  target row
- wr_lane  in  LANE_W  vertex lane (vid)
- wr_data  in  BW  element value
- flush  in  1  one-cycle pulse: commit pending row
- rd_valid  in  1  row read request
- rd_ready  out  1  read accepted when rd_valid && rd_ready
- rd_row  in  ADDR_SPACE  row to read
- rd_data_valid  out  1  one-cycle pulse, rd_data valid
- rd_data  out  D*BW  returned row
- pend  out  1  coalescing buffer holds uncommitted data
- sram_wsb  out  1  SRAM write enable, active-low
- sram_bytemask  out  D  1 = preserve lane, 0 = write lane
- sram_wdata  out  D*BW  SRAM write data
- sram_waddr  out  ADDR_SPACE  SRAM write row
- sram_raddr  out  ADDR_SPACE  SRAM read row, registered
- sram_rdata  in  D*BW  SRAM read data, valid 1 cycle after raddr is sampled

## Operation

**Lane mapping**
- vid v maps to bytemask bit D-1-v and to wdata/rdata bits [(D-1-v)*BW +: BW].

**Coalescing buffer**
- Holds pend_row, pend_mask (D bits; 1 = lane written) and pend_data.
- Empty buffer: an accepted write loads the row, sets its lane, and sets pend.
- Same row: the write merges. A repeated lane overwrites.
- Different row: the buffer commits, then loads the new write on the same edge.

**Commit cycle (pend=1)**
- Combinational outputs: sram_wsb=0, sram_waddr=pend_row, sram_bytemask=~mapped pend_mask, sram_wdata=mapped pend_data (unwritten lanes 0).
- Triggers:
  - (a) different-row write accepted;
  - (b) flush_q set — flush is latched into flush_q and held until serviced;
  - (c) hazard: read FSM in R_IDLE && rd_valid && rd_row==pend_row;
  - (d) pend_mask all ones.
- For (b), (c) and (d), wr_ready=0 that cycle. After the edge, pend=0 and flush_q clears.
- flush_q with pend=0 clears with no SRAM write.

**Read FSM**
- R_IDLE: rd_ready=1 unless hazard. On accept, sram_raddr<=rd_row, go to R_ISSUE.
- R_ISSUE: the SRAM samples raddr. Go to R_CAP.
- R_CAP: rd_data<=sram_rdata, rd_data_valid<=1 (one-cycle pulse). Go to R_IDLE.

**Idle SRAM write outputs**
- sram_wsb=1, sram_bytemask all ones, sram_wdata=0.

## Timing

**Write**
- Accept at edge E. A commit triggered by (a) is visible in memory after the commit edge.
- Full row: commit occurs in the cycle after the edge that sets the last lane.

**Read**
- Accept at edge E0. rd_data_valid is high in the cycle after E2.
- rd_ready=0 in R_ISSUE and R_CAP, so the sustained rate is one read per 3 cycles.
- Hazard: commit occurs in cycle C. The read is accepted at the edge ending C+1 and returns committed data.

**Reset values**
- wr_ready=1, rd_ready=1, rd_data_valid=0, rd_data=0, pend=0.
- sram_wsb=1, sram_bytemask all ones, sram_wdata=0, sram_waddr=0, sram_raddr=0.
- Reset mid-operation discards pending data and any outstanding read; no rd_data_valid is produced.

## Configuration
**LOC_RD_CLEAR_EN**
- Defined:
  - In R_ISSUE, the block writes zeros to the row being read: sram_wsb=0, sram_waddr=sram_raddr, sram_bytemask all zeros, sram_wdata=0. The SRAM still returns the old contents.
  - wr_ready=0 and no commit occurs in that cycle. Triggers (b)–(d) defer one cycle.
- Undefined:
  - Reads are non-destructive.
  - R_ISSUE places no restriction on writes.

## Test plan
- **Coalesced write:** writes (row 3, vid 0, 5'h1F), (3, 255, 5'h0A), then flush → single sram_wsb=0 cycle with waddr=3 and bytemask zeros only at bits 255 and 0. Reading row 3 returns 5'h1F at [1279:1275] and 5'h0A at [4:0].
- **Row switch:** write row 1 then row 2 back-to-back → row 1 commits in the row-2 accept cycle, wr_ready stays 1, pend=1 for row 2.
- **Read hazard:** write (5, 7, 5'h03) then rd_valid row 5 in the next cycle → rd_ready=0 for one cycle, commit occurs, and rd_data returns 5'h03 in lane 7.
- **Full row:** 256 writes to row 9 → exactly one commit with bytemask all zeros, occurring one cycle after the last write.
- **Read clear (LOC_RD_CLEAR_EN defined):** read row 3 twice → first returns data, second returns all zeros. With the macro undefined, both reads return the same data.
- **Reset:** assert rst_n low in R_ISSUE with pend=1 → no rd_data_valid, pend=0, sram_wsb=1, and row memory is unchanged.
